uart_phy_8n1: RTL and testbench

- Bit-level UART PHY directly downstream of the memory-mapped UART lite.
- Serializes the byte from the lite's tx_data/tx_valid onto txd.
- Deserializes rxd into rx_data/rx_ready pulses that the lite's RX FIFO consumes.
- Fixed 8N1 framing (8 data bits, no parity, 1 stop bit), LSB first, with a clocks-per-bit divider.

---
 rtl/uart_phy_8n1_if.sv | 20 ++
 rtl/uart_phy_8n1.sv | 189 ++++++++++++++++++
 tb/tb_uart_phy_8n1.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_phy_8n1_if.sv
// Lite-side byte handshake between the UART lite and the 8N1 bit-level PHY.
`timescale 1ns/1ps
interface uart_phy_8n1_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_frame_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_ready, rx_frame_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_ready, rx_frame_err
  );
endinterface

// File: rtl/uart_phy_8n1.sv
// 8N1 UART PHY: LSB-first serializer on txd, mid-bit sampling deserializer on rxd.
`timescale 1ns/1ps
module uart_phy_8n1 #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic         clka,
  input  logic         rstn,
  uart_phy_8n1_if.slave lite,
  output logic         txd,
  input  logic         rxd
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  tx_state_t       tx_state;
  logic [CW-1:0]   tx_cnt;
  logic [2:0]      tx_bit;
  logic [7:0]      tx_shreg;
  logic            tx_ready_q;

  rx_state_t       rx_state;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shreg;
  logic [7:0]      rx_data_q;
  logic            rx_ready_q;
  logic            rx_err_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic            rxs;
  logic            rxs_prev;

  assign lite.tx_ready     = tx_ready_q;
  assign lite.rx_data      = rx_data_q;
  assign lite.rx_ready     = rx_ready_q;
  assign lite.rx_frame_err = rx_err_q;
  assign rxs               = sync_q[SYNC_STAGES-1];

  // txd is registered and driven one bit ahead of the shift so it changes on bit boundaries.
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_shreg   <= '0;
      tx_ready_q <= 1'b1;
      txd        <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (lite.tx_valid && tx_ready_q) begin
            tx_state   <= TX_START;
            tx_shreg   <= lite.tx_data;
            tx_cnt     <= '0;
            tx_ready_q <= 1'b0;
            txd        <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_state <= TX_DATA;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= tx_shreg[0];
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              txd      <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shreg <= {1'b0, tx_shreg[7:1]};
              txd      <= tx_shreg[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_ready_q <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          tx_state   <= TX_IDLE;
          tx_cnt     <= '0;
          tx_ready_q <= 1'b1;
          txd        <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      sync_q   <= '1;
      rxs_prev <= 1'b1;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], rxd};
      rxs_prev <= rxs;
    end
  end

  // Stop is judged at mid-bit and the FSM returns to idle there, so a start bit
  // immediately following the stop bit is still caught as a falling edge.
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shreg   <= '0;
      rx_data_q  <= '0;
      rx_ready_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_ready_q <= 1'b0;
      rx_err_q   <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rxs_prev && !rxs) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shreg <= {rxs, rx_shreg[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rxs) begin
              rx_data_q  <= rx_shreg;
              rx_ready_q <= 1'b1;
              rx_state   <= RX_IDLE;
            end else begin
              rx_err_q <= 1'b1;
              rx_state <= RX_BREAK;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_BREAK: begin
          rx_cnt <= '0;
          if (rxs) begin
            rx_state <= RX_IDLE;
          end
        end
        default: begin
          rx_state <= RX_IDLE;
          rx_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_phy_8n1.sv
// Scoreboarded bench for uart_phy_8n1 at 8 clocks per bit, with optional txd->rxd loopback.
`timescale 1ns/1ps
module tb_uart_phy_8n1;
  localparam int CPB = 8;

  logic clka = 1'b0;
  logic rstn;
  logic txd;
  logic rxd;
  logic rxd_drv;
  logic loop_en;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   err_cnt  = 0;
  logic [7:0] exp_q[$];

  uart_phy_8n1_if bus ();

  uart_phy_8n1 #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clka (clka),
    .rstn (rstn),
    .lite (bus.slave),
    .txd  (txd),
    .rxd  (rxd)
  );

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clka = ~clka;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Receive-side scoreboard: every rx_ready must match the oldest expected byte.
  always @(negedge clka) begin
    if (rstn === 1'b1) begin
      if (bus.rx_ready && bus.rx_frame_err) check("rx_both_high", 32'd1, 32'd0);
      if (bus.rx_frame_err) err_cnt++;
      if (bus.rx_ready) begin
        if (exp_q.size() == 0) check("rx_unexpected", {24'd0, bus.rx_data}, 32'h100);
        else check("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_tx_ready();
    for (int i = 0; i < 200; i++) begin
      if (bus.tx_ready) break;
      @(negedge clka);
    end
    if (!bus.tx_ready) check("tx_ready_timeout", {31'd0, bus.tx_ready}, 32'd1);
  endtask

  task automatic send_tx(input logic [7:0] d);
    wait_tx_ready();
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(posedge clka);
    @(negedge clka);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clka);
    end
    check(tag, exp_q.size(), 32'd0);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = fr[i];
      repeat (CPB) @(negedge clka);
    end
  endtask

  initial begin
    logic [9:0] fr;
    int ready_low;
    rstn = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    rxd_drv = 1'b1;
    loop_en = 1'b0;

    #23;
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    check("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    check("rst_rx_err", {31'd0, bus.rx_frame_err}, 32'd0);
    @(negedge clka);
    rstn = 1'b1;
    repeat (3) @(negedge clka);

    // TX waveform of 0x55 against an independently built 10-bit frame
    fr = {1'b1, 8'h55, 1'b0};
    ready_low = 0;
    bus.tx_data  = 8'h55;
    bus.tx_valid = 1'b1;
    @(posedge clka);
    for (int k = 0; k < 100; k++) begin
      @(negedge clka);
      if (k == 0) bus.tx_valid = 1'b0;
      if (!bus.tx_ready) ready_low++;
      if (k < 80 && (k % CPB == 0 || k % CPB == CPB - 1))
        check("tx55_txd", {31'd0, txd}, {31'd0, fr[k / CPB]});
      if (k == 80) check("tx55_ready_back", {31'd0, bus.tx_ready}, 32'd1);
      if (k == 85) check("tx55_idle_txd", {31'd0, txd}, 32'd1);
    end
    check("tx55_ready_low_cycles", ready_low, 32'd80);

    // Loopback, back-to-back with tx_valid held across the frame end
    loop_en = 1'b1;
    repeat (4) @(negedge clka);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h00);
    bus.tx_data  = 8'hA3;
    bus.tx_valid = 1'b1;
    @(posedge clka);
    @(negedge clka);
    bus.tx_data = 8'h00;
    wait_tx_ready();
    @(posedge clka);
    @(negedge clka);
    bus.tx_valid = 1'b0;
    check("b2b_second_accept", {31'd0, bus.tx_ready}, 32'd0);
    wait_drain("b2b_drain", 300);
    check("b2b_no_err", err_cnt, 32'd0);

    // Framing error followed by a held-low break
    loop_en = 1'b0;
    repeat (10) @(negedge clka);
    drive_frame(8'h7E, 1'b0);
    repeat (40) @(negedge clka);
    rxd_drv = 1'b1;
    repeat (20) @(negedge clka);
    check("ferr_count", err_cnt, 32'd1);
    check("ferr_rx_data_kept", {24'd0, bus.rx_data}, 32'h00);
    exp_q.push_back(8'h31);
    drive_frame(8'h31, 1'b1);
    wait_drain("ferr_recover_drain", 40);

    // Short glitch on an idle line
    repeat (10) @(negedge clka);
    rxd_drv = 1'b0;
    repeat (2) @(negedge clka);
    rxd_drv = 1'b1;
    repeat (30) @(negedge clka);
    check("glitch_no_err", err_cnt, 32'd1);
    exp_q.push_back(8'hC8);
    drive_frame(8'hC8, 1'b1);
    wait_drain("glitch_recover_drain", 40);

    // tx_valid during a busy frame is dropped
    loop_en = 1'b1;
    repeat (5) @(negedge clka);
    exp_q.push_back(8'h12);
    bus.tx_data  = 8'h12;
    bus.tx_valid = 1'b1;
    @(posedge clka);
    for (int k = 0; k < 22; k++) begin
      @(negedge clka);
      if (k == 0) bus.tx_valid = 1'b0;
      if (k == 20) begin
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
      end
      if (k == 21) bus.tx_valid = 1'b0;
    end
    wait_drain("busy_drop_drain", 200);
    repeat (120) @(negedge clka);
    check("busy_drop_idle_ready", {31'd0, bus.tx_ready}, 32'd1);
    check("busy_drop_idle_txd", {31'd0, txd}, 32'd1);

    // Asynchronous reset in the middle of a loopback frame
    bus.tx_data  = 8'h96;
    bus.tx_valid = 1'b1;
    @(posedge clka);
    @(negedge clka);
    bus.tx_valid = 1'b0;
    repeat (40) @(negedge clka);
    #2 rstn = 1'b0;
    #1;
    check("arst_txd", {31'd0, txd}, 32'd1);
    check("arst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    check("arst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    repeat (3) @(negedge clka);
    rstn = 1'b1;
    repeat (100) @(negedge clka);
    check("arst_no_rx", {24'd0, bus.rx_data}, 32'd0);
    exp_q.push_back(8'h5A);
    send_tx(8'h5A);
    wait_drain("arst_recover_drain", 200);
    check("final_err_count", err_cnt, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
